// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer for an SPI slave: decodes the command word of each
// chip-select frame, then issues register writes or read fetches per data word.
// Define SPI_REG_CTRL_AUTOINC_EN to step reg_addr after every write and read load.
module spi_reg_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  synced_new_data_flag,
  input  logic [DATA_WIDTH-1:0] synced_data_received,
  output logic                  clear_new_data_flag,
  output logic [DATA_WIDTH-1:0] data_to_send,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic                  xfer_done
);

  // state     | meaning
  // IDLE      | no frame; waiting for a synchronized cs fall
  // WAIT_CMD  | frame open; waiting for the command word
  // WAIT_DATA | command decoded; waiting for the next data word
  // RD_FETCH  | reg_rd_en strobe at the current address
  // RD_LOAD   | capture reg_rd_data into data_to_send
  // CLEAR     | request flag clear until the slave drops the flag
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CMD  = 3'd1,
    WAIT_DATA = 3'd2,
    RD_FETCH  = 3'd3,
    RD_LOAD   = 3'd4,
    CLEAR     = 3'd5
  } state_t;

  // Cycles a frame stays open after cs_sync rises with no flag, so a final word
  // whose synchronized flag trails the cs rise is still accepted.
  localparam logic [1:0] GRACE = 2'd3;

  state_t     state, state_next;
  logic       cs_meta, cs_sync, cs_armed;
  logic [1:0] sync_fill;
  logic       cs_fall;
  logic       dir_wr;
  logic [1:0] grace_cnt;
  logic       grace_run;
  logic       latch_cmd, wr_word, load_rd, done_next;

  // cs_armed only rises once the synchronizer holds a real sample of cs, so a
  // cs already low when reset releases is not mistaken for a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      sync_fill <= 2'b00;
      cs_armed  <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      cs_armed  <= sync_fill[1] & cs_sync;
    end
  end

  assign cs_fall = cs_armed & ~cs_sync;

  assign grace_run = ((state == WAIT_CMD) || (state == WAIT_DATA)) &&
                     cs_sync && !synced_new_data_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grace_cnt <= GRACE;
    end else if (!grace_run) begin
      grace_cnt <= GRACE;
    end else if (grace_cnt != 2'd0) begin
      grace_cnt <= grace_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    latch_cmd  = 1'b0;
    wr_word    = 1'b0;
    load_rd    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_next = WAIT_CMD;
      end
      WAIT_CMD: begin
        if (synced_new_data_flag) begin
          latch_cmd  = 1'b1;
          state_next = synced_data_received[DATA_WIDTH-1] ? CLEAR : RD_FETCH;
        end else if (cs_sync && grace_cnt == 2'd0) begin
          state_next = IDLE;
        end
      end
      WAIT_DATA: begin
        if (synced_new_data_flag) begin
          if (dir_wr) begin
            wr_word    = 1'b1;
            state_next = CLEAR;
          end else begin
            state_next = RD_FETCH;
          end
        end else if (cs_sync && grace_cnt == 2'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      RD_FETCH: state_next = RD_LOAD;
      RD_LOAD: begin
        load_rd    = 1'b1;
        state_next = CLEAR;
      end
      CLEAR: begin
        if (!synced_new_data_flag) begin
          if (cs_sync) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = WAIT_DATA;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The address steps in the cycle after its use: while reg_wr_en is high for
  // writes, and on the RD_LOAD edge for reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_wr       <= 1'b0;
      reg_addr     <= '0;
      data_to_send <= '0;
      reg_wr_en    <= 1'b0;
      reg_wr_data  <= '0;
      xfer_done    <= 1'b0;
    end else begin
      reg_wr_en <= wr_word;
      xfer_done <= done_next;
      if (latch_cmd) begin
        dir_wr   <= synced_data_received[DATA_WIDTH-1];
        reg_addr <= synced_data_received[ADDR_WIDTH-1:0];
      end
`ifdef SPI_REG_CTRL_AUTOINC_EN
      else if (reg_wr_en || load_rd) begin
        reg_addr <= reg_addr + ADDR_WIDTH'(1);
      end
`endif
      if (wr_word) reg_wr_data <= synced_data_received;
      if (load_rd) data_to_send <= reg_rd_data;
    end
  end

  assign reg_rd_en           = (state == RD_FETCH);
  assign clear_new_data_flag = (state == CLEAR);
  assign busy                = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a slave/flag model and a register file model
// drive frames; expected writes and read loads are queued and matched on output.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1;
  logic        flag = 1'b0;
  logic [15:0] rx_word = '0;
  logic        clear_new_data_flag;
  logic [15:0] data_to_send;
  logic [6:0]  reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data = 16'hDEAD;
  logic        busy;
  logic        xfer_done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  logic [15:0] mem [0:127];
  logic [15:0] exp_wr_addr[$];
  logic [15:0] exp_wr_data[$];
  logic [15:0] exp_dts[$];
  logic [15:0] wd [0:3];

  spi_reg_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) dut (
    .clk                  (clk),
    .reset                (reset),
    .cs                   (cs),
    .synced_new_data_flag (flag),
    .synced_data_received (rx_word),
    .clear_new_data_flag  (clear_new_data_flag),
    .data_to_send         (data_to_send),
    .reg_addr             (reg_addr),
    .reg_wr_en            (reg_wr_en),
    .reg_wr_data          (reg_wr_data),
    .reg_rd_en            (reg_rd_en),
    .reg_rd_data          (reg_rd_data),
    .busy                 (busy),
    .xfer_done            (xfer_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] step(input logic [6:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  // register file: data valid exactly one clock after the read strobe
  always @(posedge clk) begin
    if (reg_rd_en) reg_rd_data <= mem[reg_addr];
    else           reg_rd_data <= 16'hDEAD;
  end

  logic rd_p1 = 1'b0, rd_p2 = 1'b0, strobe_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      rd_p1 = 1'b0; rd_p2 = 1'b0; strobe_prev = 1'b0;
    end else begin
      if (reg_wr_en || reg_rd_en)
        check("strobe_rule", {30'd0, reg_wr_en & reg_rd_en, strobe_prev}, 32'd0);
      strobe_prev = reg_wr_en | reg_rd_en;
      if (xfer_done) done_cnt++;
      if (reg_wr_en) begin
        wr_cnt++;
        if (exp_wr_addr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          check("wr_addr", {25'd0, reg_addr}, {16'd0, exp_wr_addr.pop_front()});
          check("wr_data", {16'd0, reg_wr_data}, {16'd0, exp_wr_data.pop_front()});
        end
      end
      if (rd_p2) begin
        if (exp_dts.size() == 0) check("dts_unexpected", 1, 0);
        else check("data_to_send", {16'd0, data_to_send}, {16'd0, exp_dts.pop_front()});
      end
      rd_p2 = rd_p1;
      rd_p1 = reg_rd_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input logic val, input string tag);
    int n = 0;
    while (clear_new_data_flag !== val && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, clear_new_data_flag}, {31'd0, val});
  endtask

  task automatic send_word(input logic [15:0] w);
    rx_word = w;
    flag = 1'b1;
    wait_clear(1'b1, "clear_req");
    tick(2);
    flag = 1'b0;
    wait_clear(1'b0, "clear_release");
    tick(2);
  endtask

  task automatic frame_start();
    cs = 1'b0;
    tick(5);
    check("busy_in_frame", {31'd0, busy}, 1);
  endtask

  task automatic frame_end(input int done_before, input int exp_done);
    cs = 1'b1;
    tick(10);
    check("xfer_done_count", done_cnt - done_before, exp_done);
    check("busy_after", {31'd0, busy}, 0);
    check("wr_left", exp_wr_addr.size(), 0);
    check("dts_left", exp_dts.size(), 0);
  endtask

  task automatic write_frame(input logic [6:0] a0, input int n);
    int d0 = done_cnt;
    logic [6:0] a = a0;
    frame_start();
    send_word(16'h8000 | {9'd0, a0});
    for (int i = 0; i < n; i++) begin
      exp_wr_addr.push_back({9'd0, a});
      exp_wr_data.push_back(wd[i]);
      a = step(a);
      send_word(wd[i]);
    end
    frame_end(d0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dts"},   {16'd0, data_to_send}, 0);
    check({tag, "_addr"},  {25'd0, reg_addr}, 0);
    check({tag, "_wr"},    {31'd0, reg_wr_en}, 0);
    check({tag, "_rd"},    {31'd0, reg_rd_en}, 0);
    check({tag, "_busy"},  {31'd0, busy}, 0);
    check({tag, "_done"},  {31'd0, xfer_done}, 0);
    check({tag, "_clear"}, {31'd0, clear_new_data_flag}, 0);
  endtask

  initial begin
    int d0, w0;
    logic [6:0] a;
    for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    mem[16] = 16'hBEEF;
    mem[17] = 16'hCAFE;

    tick(3);
    check_idle_outputs("rst");
    reset = 1'b0;
    tick(5);

    // write burst
    wd[0] = 16'h1234; wd[1] = 16'hABCD;
    write_frame(7'h05, 2);

    // wrap at the top of the address space
    wd[0] = 16'h0F0F; wd[1] = 16'hF0F0;
    write_frame(7'h7F, 2);

    // three writes from 0x03
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    write_frame(7'h03, 3);

    // read burst: command then two dummy words
    d0 = done_cnt;
    a = 7'h10;
    frame_start();
    exp_dts.push_back(mem[a]); a = step(a);
    send_word(16'h0010);
    for (int i = 0; i < 2; i++) begin
      exp_dts.push_back(mem[a]); a = step(a);
      send_word(16'h7E00 + 16'(i));
    end
    frame_end(d0, 1);
    check("dts_hold", {16'd0, data_to_send}, {16'd0, mem[step(step(7'h10))]});

    // command only
    d0 = done_cnt;
    w0 = wr_cnt;
    frame_start();
    send_word(16'h8044);
    frame_end(d0, 1);
    check("cmd_only_writes", wr_cnt - w0, 0);

    // last flag trails the synchronized cs rise
    d0 = done_cnt;
    frame_start();
    send_word(16'h8020);
    exp_wr_addr.push_back(16'h0020); exp_wr_data.push_back(16'h5555);
    send_word(16'h5555);
    exp_wr_addr.push_back({9'd0, step(7'h20)}); exp_wr_data.push_back(16'h7777);
    cs = 1'b1;
    tick(3);
    send_word(16'h7777);
    frame_end(d0, 1);

    // reset while in CLEAR after the command word
    d0 = done_cnt;
    w0 = wr_cnt;
    frame_start();
    rx_word = 16'h8009;
    flag = 1'b1;
    wait_clear(1'b1, "clear_before_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    tick(2);
    reset = 1'b0;
    tick(2);
    flag = 1'b0;
    tick(10);
    check("no_resume_busy", {31'd0, busy}, 0);
    check("no_resume_done", done_cnt - d0, 0);
    check("no_resume_writes", wr_cnt - w0, 0);
    cs = 1'b1;
    tick(6);
    wd[0] = 16'h4242;
    write_frame(7'h11, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

System-clock-domain controller that sequences the SPI slave interface as a register-access port. It consumes each synchronized received word, decodes the first word of a chip-select frame as a read/write command with start address, then drives register write strobes or read fetches for every following word. It loads read data for the next outgoing word and runs the new-data-flag clear handshake.

## Interface
- DATA_WIDTH, 16, SPI word width; must match the slave interface.
- ADDR_WIDTH, 7, register address width; must be ≤ DATA_WIDTH-1.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  raw SPI chip select (active low, asynchronous to clk); two-flop synchronized internally, flops reset to 1.
- synced_new_data_flag  in  1  word-received flag from the slave, already in the clk domain.
- synced_data_received  in  DATA_WIDTH  received word; valid while synced_new_data_flag=1.
- clear_new_data_flag  out  1  flag clear request to the slave.
- data_to_send  out  DATA_WIDTH  next word the slave shifts out.
- reg_addr  out  ADDR_WIDTH  register address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  DATA_WIDTH  write data, valid with reg_wr_en.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  DATA_WIDTH  read data, valid exactly 1 clk after reg_rd_en.
- busy  out  1  high in every state except IDLE.
- xfer_done  out  1  one-cycle pulse at the end of a frame that decoded a command.

## Operation
- Command word layout:
  - bit DATA_WIDTH-1: 1 = write, 0 = read.
  - bits ADDR_WIDTH-1:0: start address.
  - All other bits are ignored.
- States: IDLE, WAIT_CMD, WAIT_DATA, RD_FETCH, RD_LOAD, CLEAR.
- IDLE: cs_sync falls -> WAIT_CMD.
- WAIT_CMD: flag=1 -> latch dir and reg_addr.
  - Write -> CLEAR.
  - Read -> RD_FETCH.
- RD_FETCH: assert reg_rd_en for 1 clk -> RD_LOAD.
- RD_LOAD: data_to_send <= reg_rd_data; advance address -> CLEAR.
- WAIT_DATA: flag=1 ->
  - Write: reg_wr_en=1, reg_wr_data=word at current address; advance address -> CLEAR.
  - Read: the received word is a dummy and is discarded -> RD_FETCH.
- CLEAR:
  - clear_new_data_flag=1, held until synced_new_data_flag reads 0.
  - Then: cs_sync=1 -> IDLE with xfer_done pulse; otherwise -> WAIT_DATA.
- Frame end:
  - In WAIT_CMD or WAIT_DATA, flag has priority over cs_sync=1. A final word whose flag arrives with or after cs rise is still processed.
  - With flag=0 and cs_sync=1: WAIT_DATA -> IDLE with xfer_done pulse; WAIT_CMD -> IDLE with no pulse.
- RD_FETCH and RD_LOAD always complete before cs_sync is honoured.
- data_to_send holds its value between loads and is not cleared at frame end.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH; 0x7F+1 -> 0x00.

## Timing
- Reset: state IDLE. All outputs 0: data_to_send=0, reg_addr=0, strobes=0, busy=0, xfer_done=0.
- Reset mid-frame returns to IDLE immediately. A frame in progress resumes only after cs_sync goes high and then falls again.
- Flag at the input to reg_wr_en: 1 clk.
- Flag at the input to data_to_send update: 3 clk (WAIT -> RD_FETCH -> RD_LOAD -> registered output).
- Master inter-word gap must be ≥ 2 synchronizer stages + 3 clk + the slave's reload window.
- CLEAR exit takes at least 3 clk (slave flag round trip through the 2-flop synchronizer).
- reg_wr_en and reg_rd_en are never both high and are never high for 2 consecutive clk.

## Configuration
- SPI_REG_CTRL_AUTOINC_EN defined:
  - reg_addr increments after every data word write.
  - reg_addr increments after every RD_LOAD.
  - Increment wraps at 2^ADDR_WIDTH.
- Undefined:
  - reg_addr stays at the command address for the whole frame.
  - Repeated writes and reads hit the same register.

## Test plan
- Reset: assert reset mid-CLEAR -> all outputs 0, state IDLE, no strobe; the next cs fall starts a fresh frame.
- Write burst (AUTOINC_EN): cs low, words 0x8005, 0x1234, 0xABCD -> reg_wr_en at addr 0x05 data 0x1234, then addr 0x06 data 0xABCD; one xfer_done after cs rise.
- Read burst (AUTOINC_EN): regs[0x10]=0xBEEF, regs[0x11]=0xCAFE; command 0x0010, then 2 dummy words -> data_to_send 0xBEEF after the command, then 0xCAFE, then regs[0x12].
- Wrap: write command 0x807F plus 2 data words -> writes to 0x7F, then 0x00.
- AUTOINC undefined: command 0x8003 plus 3 data words -> three writes, all to 0x03.
- Late flag: last flag raised 1 clk after cs_sync rises -> write still performed before IDLE.
- Command only: command word then cs rise -> no strobe beyond the decode, xfer_done pulses once.
